// File: rtl/vga_pixel_timing_if.sv
// vga_pixel_timing_if: raster/timing bundle from the VGA timing generator
// to its consumers (renderer paint logic, DAC output register).
//   clock_25M : pixel clock (clock_50M / 2)
//   sx, sy    : raster position
//   hsync     : horizontal sync, active-low
//   vsync     : vertical sync, active-low
//   de        : display enable, high in the visible area
//   frame     : one-pixel pulse at the start of vertical blanking
// The master modport is the timing generator; the slave modport is any consumer.
interface vga_pixel_timing_if;
    logic       clock_25M;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       frame;

    modport master (output clock_25M, sx, sy, hsync, vsync, de, frame);
    modport slave  (input  clock_25M, sx, sy, hsync, vsync, de, frame);
endinterface

// File: rtl/vga_pixel_timing.sv
// vga_pixel_timing: 640x480@60 raster generator with a built-in /2 pixel-clock
// divider, all in the clock_50M domain.
//   clock_50M : only clock, rising edge
//   reset_n   : asynchronous active-low reset
//   vga       : master side of vga_pixel_timing_if (clock_25M, sx, sy,
//               hsync, vsync, de, frame)
// The counters advance on the clock_50M edge that drops clock_25M, so they
// are stable at every clock_25M rising edge. All decodes are combinational
// from the counter registers (zero latency).
module vga_pixel_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic               clock_50M,
    input  logic               reset_n,
    vga_pixel_timing_if.master vga
);
    localparam logic [9:0] H_TOTAL    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_TOTAL    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       clk_div;
    logic [9:0] sx_q;
    logic [9:0] sy_q;
    logic       pix_en;
    logic       sx_wrap;

    // Pixel enable is the divider register itself: true on the edge where
    // clock_25M is about to fall.
    assign pix_en  = clk_div;
    // ">=" rather than "==" so an out-of-range count recovers on the next pixel.
    assign sx_wrap = (sx_q >= H_TOTAL - 10'd1);

    always_ff @(posedge clock_50M or negedge reset_n) begin
        if (!reset_n) begin
            clk_div <= 1'b0;
            sx_q    <= 10'd0;
            sy_q    <= 10'd0;
        end else begin
            clk_div <= ~clk_div;
            if (pix_en) begin
                sx_q <= sx_wrap ? 10'd0 : sx_q + 10'd1;
                // sy past its total recovers regardless of sx; otherwise it
                // only moves when the line wraps.
                if (sy_q >= V_TOTAL || (sx_wrap && sy_q >= V_TOTAL - 10'd1))
                    sy_q <= 10'd0;
                else if (sx_wrap)
                    sy_q <= sy_q + 10'd1;
            end
        end
    end

    assign vga.clock_25M = clk_div;
    assign vga.sx        = sx_q;
    assign vga.sy        = sy_q;
    assign vga.de        = (sx_q < H_VIS) && (sy_q < V_VIS);
    assign vga.hsync     = !((sx_q >= HS_START) && (sx_q < HS_END));
    assign vga.vsync     = !((sy_q >= VS_START) && (sy_q < VS_END));
    assign vga.frame     = (sy_q == V_VIS) && (sx_q == 10'd0);
endmodule

// File: tb/tb_vga_pixel_timing.sv
`timescale 1ns/1ps
// Two instances share clock and reset: a full-size 640x480 one (line-level
// checks) and a shrunken one so that whole frames fit in a short run.
// The reference model derives every output from the number of clock_50M
// edges since reset release using plain division/modulo.
module tb_vga_pixel_timing;
    localparam int S_HA = 20, S_HF = 3, S_HS = 5, S_HB = 4;
    localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 32
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 19

    logic clock_50M = 1'b0;
    logic reset_n   = 1'b0;

    vga_pixel_timing_if sm_if ();
    vga_pixel_timing_if bg_if ();

    vga_pixel_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .clock_50M (clock_50M),
        .reset_n   (reset_n),
        .vga       (sm_if)
    );

    vga_pixel_timing u_big (
        .clock_50M (clock_50M),
        .reset_n   (reset_n),
        .vga       (bg_if)
    );

    always #10 clock_50M = ~clock_50M;

    typedef struct packed {
        logic       c25;
        logic [9:0] sx;
        logic [9:0] sy;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fr;
    } vga_exp_t;

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;   // clock_50M rising edges since reset release

    function automatic vga_exp_t model(int tt, int ha, int hf, int hs, int hb,
                                       int va, int vf, int vs, int vb);
        vga_exp_t m;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int p  = tt / 2;            // pixels completed
        int x  = p % ht;
        int y  = (p / ht) % vt;
        m.c25 = (tt % 2) == 1;
        m.sx  = 10'(x);
        m.sy  = 10'(y);
        m.hs  = !(x >= ha + hf && x < ha + hf + hs);
        m.vs  = !(y >= va + vf && y < va + vf + vs);
        m.de  = (x < ha) && (y < va);
        m.fr  = (y == va) && (x == 0);
        return m;
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_one(string n, vga_exp_t e, logic c25, logic [9:0] sx,
                             logic [9:0] sy, logic hs, logic vs, logic de, logic fr);
        cmp({n, ".clock_25M"}, 32'(c25), 32'(e.c25));
        cmp({n, ".sx"},        32'(sx),  32'(e.sx));
        cmp({n, ".sy"},        32'(sy),  32'(e.sy));
        cmp({n, ".hsync"},     32'(hs),  32'(e.hs));
        cmp({n, ".vsync"},     32'(vs),  32'(e.vs));
        cmp({n, ".de"},        32'(de),  32'(e.de));
        cmp({n, ".frame"},     32'(fr),  32'(e.fr));
    endtask

    task automatic check_both();
        check_one("small", model(t, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB),
                  sm_if.clock_25M, sm_if.sx, sm_if.sy, sm_if.hsync, sm_if.vsync,
                  sm_if.de, sm_if.frame);
        check_one("big", model(t, 640, 16, 96, 48, 480, 10, 2, 33),
                  bg_if.clock_25M, bg_if.sx, bg_if.sy, bg_if.hsync, bg_if.vsync,
                  bg_if.de, bg_if.frame);
    endtask

    // One clock_50M cycle; sample on the falling edge.
    task automatic tick(bit adv);
        @(posedge clock_50M);
        if (adv) t++;
        @(negedge clock_50M);
        check_both();
    endtask

    initial begin
        int hs_low0, nframes, cyc, de_cyc, vs_cyc, fr_cyc, max_sx, max_sy;
        logic prev_fr;

        // Reset held while the clock runs: everything parked at 0,0.
        @(negedge clock_50M);
        check_both();
        repeat (3) tick(1'b0);
        #2 reset_n = 1'b1;

        // First line of the full-size raster plus the wrap into line 1.
        hs_low0 = 0;
        repeat (1700) begin
            tick(1'b1);
            if (bg_if.sy == 10'd0 && bg_if.hsync == 1'b0) hs_low0++;
        end
        cmp("big.hsync_low_cycles_line0", 32'(hs_low0), 32'(2 * 96));

        // Small raster over several whole frames, measured pulse to pulse.
        nframes = 0; cyc = 0; de_cyc = 0; vs_cyc = 0; fr_cyc = 0;
        max_sx = 0; max_sy = 0;
        prev_fr = sm_if.frame;
        repeat (4 * 2 * S_HT * S_VT + 200) begin
            tick(1'b1);
            if (sm_if.frame && !prev_fr) begin
                if (nframes > 0) begin
                    cmp("small.frame_len_cycles", 32'(cyc),        32'(2 * S_HT * S_VT));
                    cmp("small.de_pixels",        32'(de_cyc / 2), 32'(S_HA * S_VA));
                    cmp("small.vsync_low_pixels", 32'(vs_cyc / 2), 32'(S_HT * S_VS));
                    cmp("small.frame_hi_cycles",  32'(fr_cyc),     32'd2);
                    cmp("small.sx_max",           32'(max_sx),     32'(S_HT - 1));
                    cmp("small.sy_max",           32'(max_sy),     32'(S_VT - 1));
                end
                nframes++;
                cyc = 0; de_cyc = 0; vs_cyc = 0; fr_cyc = 0; max_sx = 0; max_sy = 0;
            end
            prev_fr = sm_if.frame;
            cyc++;
            if (sm_if.de)     de_cyc++;
            if (!sm_if.vsync) vs_cyc++;
            if (sm_if.frame)  fr_cyc++;
            if (int'(sm_if.sx) > max_sx) max_sx = int'(sm_if.sx);
            if (int'(sm_if.sy) > max_sy) max_sy = int'(sm_if.sy);
        end
        cmp("small.frame_pulse_count", 32'(nframes), 32'd4);

        // Random mid-frame resets asserted between clock edges.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(40, 1300)) tick(1'b1);
            #($urandom_range(1, 7));
            reset_n = 1'b0;
            #1;
            t = 0;
            check_both();
            repeat ($urandom_range(1, 4)) tick(1'b0);
            #2 reset_n = 1'b1;
        end
        repeat (300) tick(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
